// File: rtl/qsys_pio_pkg.sv
// rtl/qsys_pio_pkg.sv - shared register map and edge-mode encodings for the PIO
package qsys_pio_pkg;

    typedef enum logic [2:0] {
        ADDR_DATA        = 3'd0,
        ADDR_DIRECTION   = 3'd1,
        ADDR_IRQMASK     = 3'd2,
        ADDR_EDGECAPTURE = 3'd3,
        ADDR_OUTSET      = 3'd4,
        ADDR_OUTCLEAR    = 3'd5
    } pio_addr_e;

    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;

endpackage

// File: rtl/qsys_pio_if.sv
// rtl/qsys_pio_if.sv - Avalon-MM slave register bus for the PIO
interface qsys_pio_if;

    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );

endinterface

// File: rtl/qsys_pio_edge_cap.sv
// rtl/qsys_pio_edge_cap.sv - pin synchroniser, per-bit edge detect and sticky capture
import qsys_pio_pkg::*;

module qsys_pio_edge_cap #(
    parameter int WIDTH     = 4,
    parameter int EDGE_TYPE = EDGE_RISING
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_port,
    input  logic [WIDTH-1:0] clr,
    output logic [WIDTH-1:0] in_sync,
    output logic [WIDTH-1:0] edge_cap
);

    logic [WIDTH-1:0] in_s1;
    logic [WIDTH-1:0] in_prev;
    logic [WIDTH-1:0] edge_det;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_s1   <= '0;
            in_sync <= '0;
            in_prev <= '0;
        end else begin
            in_s1   <= in_port;
            in_sync <= in_s1;
            in_prev <= in_sync;
        end
    end

    always_comb begin
        edge_det = '0;
        case (EDGE_TYPE)
            EDGE_FALLING: edge_det = ~in_sync & in_prev;
            EDGE_ANY:     edge_det = in_sync ^ in_prev;
            default:      edge_det = in_sync & ~in_prev;
        endcase
    end

    // A fresh edge overrides a same-cycle clear so no event is ever dropped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_cap <= '0;
        end else begin
            edge_cap <= (edge_cap & ~clr) | edge_det;
        end
    end

endmodule

// File: rtl/qsys_pio_gen.sv
// rtl/qsys_pio_gen.sv - parametrised bidirectional PIO slave with edge-capture interrupt
import qsys_pio_pkg::*;

module qsys_pio_gen #(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] OUT_RESET = '0,
    parameter logic [WIDTH-1:0] DIR_RESET = '0,
    parameter int               EDGE_TYPE = EDGE_RISING
) (
    input  logic             clk,
    input  logic             reset_n,
    qsys_pio_if.slave        bus,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic [WIDTH-1:0] oe,
    output logic             irq
);

    logic             wr;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] data_out;
    logic [WIDTH-1:0] dir;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_cap;
    logic [WIDTH-1:0] in_sync;
    logic [WIDTH-1:0] cap_clr;
    logic [31:0]      rd_word;
    logic             unused_writedata;

    assign wr               = bus.chipselect & ~bus.write_n;
    assign wd               = bus.writedata[WIDTH-1:0];
    assign unused_writedata = ^bus.writedata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out <= OUT_RESET;
            dir      <= DIR_RESET;
            irq_mask <= '0;
        end else if (wr) begin
            case (bus.address)
                ADDR_DATA:      data_out <= wd;
                ADDR_DIRECTION: dir      <= wd;
                ADDR_IRQMASK:   irq_mask <= wd;
                ADDR_OUTSET:    data_out <= data_out | wd;
                ADDR_OUTCLEAR:  data_out <= data_out & ~wd;
                default:        ;
            endcase
        end
    end

    assign cap_clr = (wr && bus.address == ADDR_EDGECAPTURE) ? wd : '0;

    qsys_pio_edge_cap #(
        .WIDTH     (WIDTH),
        .EDGE_TYPE (EDGE_TYPE)
    ) u_edge_cap (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_port  (in_port),
        .clr      (cap_clr),
        .in_sync  (in_sync),
        .edge_cap (edge_cap)
    );

    // Output bits read back the driven value; input bits read the synchronised pin.
    always_comb begin
        rd_word = '0;
        case (bus.address)
            ADDR_DATA:        rd_word[WIDTH-1:0] = (dir & data_out) | (~dir & in_sync);
            ADDR_DIRECTION:   rd_word[WIDTH-1:0] = dir;
            ADDR_IRQMASK:     rd_word[WIDTH-1:0] = irq_mask;
            ADDR_EDGECAPTURE: rd_word[WIDTH-1:0] = edge_cap;
            default:          rd_word = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.readdata <= '0;
            irq          <= 1'b0;
        end else begin
            if (bus.chipselect) begin
                bus.readdata <= rd_word;
            end
            irq <= |(edge_cap & irq_mask);
        end
    end

    assign out_port = data_out;
    assign oe       = dir;

endmodule

// File: tb/tb_qsys_pio_gen.sv
// tb/tb_qsys_pio_gen.sv - self-checking bench for qsys_pio_gen (WIDTH=8, rising edges)
module tb_qsys_pio_gen;

    localparam int W = 8;

    logic         clk;
    logic         reset_n;
    logic [W-1:0] in_port;
    logic [W-1:0] out_port;
    logic [W-1:0] oe;
    logic         irq;

    int total;
    int bad;

    logic [31:0] exp_q[$];
    string       tag_q[$];

    qsys_pio_if bus ();

    qsys_pio_gen #(
        .WIDTH     (W),
        .OUT_RESET (8'hA5),
        .DIR_RESET (8'h00),
        .EDGE_TYPE (0)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus),
        .in_port  (in_port),
        .out_port (out_port),
        .oe       (oe),
        .irq      (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.address    = a;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        bus.writedata  = d;
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        @(negedge clk);
        bus.address    = a;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b1;
        @(negedge clk);
        bus.chipselect = 1'b0;
        d = bus.readdata;
    endtask

    // Scoreboard: expectation queued when the read is issued, retired when data returns.
    task automatic read_expect(input logic [2:0] a, input logic [31:0] e, input string tag);
        logic [31:0] got;
        logic [31:0] want;
        string       name;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        bus_read(a, got);
        want = exp_q.pop_front();
        name = tag_q.pop_front();
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: readdata=0x%08h expected 0x%08h", name, got, want);
        end
    endtask

    task automatic test_reset;
        reset_n        = 1'b0;
        in_port        = '0;
        bus.address    = '0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;
        repeat (3) @(negedge clk);
        total++;
        if (out_port !== 8'hA5) begin bad++; $display("FAIL reset_out: out_port=0x%02h expected 0xa5", out_port); end
        total++;
        if (oe !== 8'h00) begin bad++; $display("FAIL reset_oe: oe=0x%02h expected 0x00", oe); end
        total++;
        if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq: irq=%b expected 0", irq); end
        total++;
        if (bus.readdata !== 32'h0) begin bad++; $display("FAIL reset_rd: readdata=0x%08h expected 0", bus.readdata); end
        reset_n = 1'b1;
        in_port = 8'h3C;
        repeat (3) @(negedge clk);
        read_expect(3'd0, 32'h3C, "reset_data_in");
    endtask

    task automatic test_dir_data;
        bus_write(3'd1, 32'h0F);
        bus_write(3'd0, 32'h12);
        in_port = 8'hB0;
        repeat (3) @(negedge clk);
        read_expect(3'd0, 32'hB2, "mixed_data");
        read_expect(3'd1, 32'h0F, "dir_rd");
        total++;
        if (out_port !== 8'h12) begin bad++; $display("FAIL dd_out: out_port=0x%02h expected 0x12", out_port); end
        total++;
        if (oe !== 8'h0F) begin bad++; $display("FAIL dd_oe: oe=0x%02h expected 0x0f", oe); end
    endtask

    task automatic test_set_clear;
        logic [31:0] held;
        bus_write(3'd0, 32'h81);
        bus_write(3'd4, 32'h06);
        total++;
        if (out_port !== 8'h87) begin bad++; $display("FAIL outset: out_port=0x%02h expected 0x87", out_port); end
        bus_write(3'd5, 32'h80);
        total++;
        if (out_port !== 8'h07) begin bad++; $display("FAIL outclear: out_port=0x%02h expected 0x07", out_port); end
        read_expect(3'd4, 32'h0, "outset_rd");
        read_expect(3'd5, 32'h0, "outclear_rd");
        bus_write(3'd6, 32'hFF);
        read_expect(3'd6, 32'h0, "rsvd_rd");
        total++;
        if (out_port !== 8'h07) begin bad++; $display("FAIL rsvd_wr: out_port=0x%02h expected 0x07", out_port); end
        bus_write(3'd1, 32'hFF);
        bus_write(3'd0, 32'hABCDEF5A);
        total++;
        if (out_port !== 8'h5A) begin bad++; $display("FAIL wide_wr: out_port=0x%02h expected 0x5a", out_port); end
        read_expect(3'd0, 32'h5A, "upper_zero");
        held = 32'h5A;
        bus.address = 3'd3;
        repeat (2) @(negedge clk);
        total++;
        if (bus.readdata !== held) begin bad++; $display("FAIL rd_hold: readdata=0x%08h expected 0x%08h", bus.readdata, held); end
        bus_write(3'd1, 32'h00);
    endtask

    task automatic test_edge_irq;
        in_port = 8'h00;
        repeat (4) @(negedge clk);
        bus_write(3'd3, 32'hFF);
        read_expect(3'd3, 32'h0, "cap_cleared");
        bus_write(3'd2, 32'h01);
        @(negedge clk);
        in_port = 8'h01;
        repeat (3) @(negedge clk);
        total++;
        if (irq !== 1'b0) begin bad++; $display("FAIL irq_early: irq=%b expected 0", irq); end
        @(negedge clk);
        total++;
        if (irq !== 1'b1) begin bad++; $display("FAIL irq_rise: irq=%b expected 1", irq); end
        read_expect(3'd3, 32'h01, "cap_rise");
        bus_write(3'd3, 32'h01);
        @(negedge clk);
        total++;
        if (irq !== 1'b0) begin bad++; $display("FAIL irq_clear: irq=%b expected 0", irq); end
        in_port = 8'h00;
        repeat (5) @(negedge clk);
        read_expect(3'd3, 32'h0, "no_fall_cap");
        total++;
        if (irq !== 1'b0) begin bad++; $display("FAIL irq_fall: irq=%b expected 0", irq); end
    endtask

    task automatic test_edge_wins;
        bus_write(3'd2, 32'h00);
        in_port = 8'h08;
        repeat (5) @(negedge clk);
        @(negedge clk);
        in_port = 8'h0C;
        @(negedge clk);
        bus_write(3'd3, 32'h0C);
        read_expect(3'd3, 32'h04, "edge_wins");
    endtask

    task automatic test_reset_mid;
        in_port = 8'h00;
        repeat (4) @(negedge clk);
        bus_write(3'd3, 32'hFF);
        bus_write(3'd2, 32'hFF);
        bus_write(3'd1, 32'hF0);
        @(negedge clk);
        in_port = 8'hFF;
        repeat (4) @(negedge clk);
        read_expect(3'd3, 32'hFF, "cap_all");
        total++;
        if (irq !== 1'b1) begin bad++; $display("FAIL irq_all: irq=%b expected 1", irq); end
        @(negedge clk);
        bus.address    = 3'd0;
        bus.writedata  = 32'h33;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        #2 reset_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_port = ~in_port;
        end
        @(negedge clk);
        in_port        = 8'h00;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        total++;
        if (out_port !== 8'hA5) begin bad++; $display("FAIL mid_out: out_port=0x%02h expected 0xa5", out_port); end
        total++;
        if (oe !== 8'h00 || irq !== 1'b0 || bus.readdata !== 32'h0) begin
            bad++;
            $display("FAIL mid_state: oe=0x%02h irq=%b readdata=0x%08h expected 0/0/0", oe, irq, bus.readdata);
        end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        total++;
        if (irq !== 1'b0) begin bad++; $display("FAIL post_irq: irq=%b expected 0", irq); end
        read_expect(3'd3, 32'h0, "post_cap");
        read_expect(3'd2, 32'h0, "post_mask");
        read_expect(3'd1, 32'h0, "post_dir");
        read_expect(3'd0, 32'h0, "post_data");
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_dir_data();
        test_set_clear();
        test_edge_irq();
        test_edge_wins();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/qsys_pio_gen.md
Name: qsys_pio_gen

Overview:
Parametrised general-purpose I/O slave on the Avalon-MM fabric, next generation of the fixed 4-bit output-only PIO. Adds:
- configurable width
- per-bit direction control with tristate enable
- synchronised input sampling
- edge capture with maskable interrupt
- atomic bit set/clear
Sits between the Qsys interconnect and board pins (LEDs, buttons, PHY straps).

Parameters:
WIDTH, 4, number of I/O bits (1..32)
OUT_RESET, 0, out_port reset value (WIDTH bits)
DIR_RESET, 0, direction register reset value; 1 = output
EDGE_TYPE, 0, capture mode: 0 rising, 1 falling, 2 any edge

Ports:
clk  in  1  system clock
reset_n  in  1  reset
address  in  3  word address of register
chipselect  in  1  slave select
write_n  in  1  active-low write strobe
writedata  in  32  write data; bits above WIDTH ignored
readdata  out  32  registered read data; bits above WIDTH read 0
in_port  in  WIDTH  asynchronous pin inputs
out_port  out  WIDTH  output data register
oe  out  WIDTH  per-bit output enable (= direction register)
irq  out  1  level interrupt, active high

Behaviour:
- Reset: reset_n, asynchronous, active-low; clock clk.
- Values on reset:
  - data_out = OUT_RESET
  - dir = DIR_RESET
  - irq_mask = 0
  - edge_cap = 0
  - sync stages = 0
  - readdata = 0
  - irq = 0
- Write strobe: chipselect && !write_n. Registers update on the clk edge after the strobe.
- Register map:
  - 0 DATA:
    - Read: per bit, dir ? data_out : in_sync.
    - Write: data_out <= writedata[WIDTH-1:0].
  - 1 DIRECTION: R/W dir.
  - 2 IRQMASK: R/W irq_mask.
  - 3 EDGECAPTURE: read edge_cap; write-1-to-clear per bit.
  - 4 OUTSET: write only; data_out |= wd. Reads 0.
  - 5 OUTCLEAR: write only; data_out &= ~wd. Reads 0.
  - 6, 7: reserved. Reads 0, writes ignored.
- Read latency 1:
  - readdata is registered every cycle with chipselect high. It holds its value when chipselect is low.
  - Reading has no side effects.
- Input path:
  - 2-flop synchroniser (in_s1 -> in_sync), plus in_prev = in_sync delayed one cycle.
  - Pin change to DATA-readable: 2 cycles.
  - Pin change to edge_cap set: 3 cycles.
- Edge detect per bit:
  - rising: in_sync & ~in_prev
  - falling: ~in_sync & in_prev
  - any: in_sync ^ in_prev
- Edge detect applies regardless of dir; captures on output bits are masked only by irq_mask.
- edge_cap bit is sticky until cleared. Next value: (edge_cap & ~clr) | edge_det.
  - Simultaneous clear and new edge on the same bit: bit stays set (edge wins).
- irq = registered |(edge_cap & irq_mask). Asserts 1 cycle after edge_cap/mask become overlapping; deasserts 1 cycle after clear.
- out_port = data_out always, independent of dir. oe = dir. Pad tristate is external.
- Reset mid-transaction: the write is lost, all state returns to reset values, and edges seen during reset are not captured.
- WIDTH < 32: writedata upper bits are dropped and readdata upper bits are zero-filled.

Decomposition:
- Shared package qsys_pio_pkg holds:
  - register address constants ADDR_DATA .. ADDR_OUTCLEAR
  - EDGE_RISING / EDGE_FALLING / EDGE_ANY encodings
- One natural sub-module, qsys_pio_edge_cap (per-bit synchroniser, edge detect, sticky capture; parametrised WIDTH, EDGE_TYPE).
- Register file and read mux stay in the top.

Test Plan:
- Reset, WIDTH=8, OUT_RESET=8'hA5 -> out_port=0xA5, oe=0, irq=0. Read addr 0 with in_port=0x3C returns 0x3C one cycle after chipselect.
- Write DIR=0x0F, DATA=0x12, in_port=0xB0 -> read DATA = 0xB2; out_port=0x12, oe=0x0F.
- DATA=0x81, OUTSET 0x06 -> out_port=0x87; then OUTCLEAR 0x80 -> 0x07; reads of addr 4/5 return 0.
- EDGE_TYPE=0, IRQMASK=0x01, in_port[0] 0->1 -> edge_cap=0x01 after 3 clk, irq high 1 clk later. Write 0x01 to addr 3 -> irq low next cycle. A falling edge does not set edge_cap.
- Clear write to addr 3 in the same cycle edge_det[2] fires -> edge_cap[2] remains 1.
- Assert reset_n low mid-burst of in_port toggles with edge_cap=0xFF -> all registers at reset values, no capture of toggles during reset, irq=0.
